// File: rtl/h264_pkg.sv
// Shared H.264 data-path definitions: scan orders, FSM states, macroblock geometry
// and the raster-to-H.264 4x4 block numbering helper.
package h264_pkg;

   typedef enum logic {
      MB_RASTER = 1'b0,
      BLK4_ZZ   = 1'b1
   } scan_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   localparam int MB_SIZE      = 16;
   localparam int BLK_SIZE     = 4;
   localparam int BEATS_PER_MB = 64;

   // H.264 numbers 4x4 blocks by 8x8 quadrant first, then by position inside the quadrant.
   function automatic logic [3:0] raster_to_blk_idx(input logic [1:0] row4,
                                                     input logic [1:0] col4);
      return {row4[1], col4[1], row4[0], col4[0]};
   endfunction

endpackage

// File: rtl/mb_beat_decode.sv
// Maps a beat number inside a 16x16 macroblock to its 4-pixel row segment offset
// and H.264 4x4 block index, for either scan order.
module mb_beat_decode
   import h264_pkg::*;
(
   input  scan_mode_e mode,
   input  logic [5:0] cnt,
   output logic [3:0] x_off,
   output logic [3:0] y_off,
   output logic [3:0] blk_idx
);

   logic [1:0] row4;
   logic [1:0] col4;

   // Raster walks 16 rows of four segments; the double-Z order walks 16 blocks of four rows.
   always_comb begin
      row4    = 2'b00;
      col4    = 2'b00;
      x_off   = 4'd0;
      y_off   = 4'd0;
      blk_idx = 4'd0;
      if (mode == MB_RASTER) begin
         col4    = cnt[1:0];
         row4    = cnt[5:4];
         x_off   = 4'(BLK_SIZE * int'(col4));
         y_off   = cnt[5:2];
         blk_idx = raster_to_blk_idx(row4, col4);
      end else begin
         col4    = {cnt[4], cnt[2]};
         row4    = {cnt[5], cnt[3]};
         x_off   = 4'(BLK_SIZE * int'(col4));
         y_off   = {row4, cnt[1:0]};
         blk_idx = cnt[5:2];
      end
   end

endmodule

// File: rtl/mb_scan_addr_gen.sv
// Macroblock scan address generator: walks a luma frame MB by MB and emits one
// 4-pixel row segment per valid/ready beat, with position flags and a done pulse.
module mb_scan_addr_gen
   import h264_pkg::*;
#(
   parameter int WIDTH  = 352,
   parameter int HEIGHT = 288,
   parameter int X_W    = $clog2(WIDTH),
   parameter int Y_W    = $clog2(HEIGHT),
   parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] addr,
   output logic [X_W-5:0]    mb_x,
   output logic [Y_W-5:0]    mb_y,
   output logic [3:0]        blk_idx,
   output logic              first_in_mb,
   output logic              last_in_mb,
   output logic              last_in_mbrow,
   output logic              last_in_frame,
   output logic              busy,
   output logic              done
);

   localparam int MB_COLS = WIDTH / MB_SIZE;
   localparam int MB_ROWS = HEIGHT / MB_SIZE;
   localparam int MBX_W   = X_W - 4;
   localparam int MBY_W   = Y_W - 4;

   if ((WIDTH % MB_SIZE) != 0 || (HEIGHT % MB_SIZE) != 0) begin : g_bad_geometry
      $error("mb_scan_addr_gen: WIDTH and HEIGHT must be multiples of 16");
   end

   scan_state_e state;
   scan_state_e state_n;
   scan_mode_e  mode_q;
   logic [5:0]  cnt;
   logic [3:0]  x_off;
   logic [3:0]  y_off;
   logic        fire;
   logic        mb_end;
   logic        row_end;
   logic        frame_end;

   assign fire      = out_valid && out_ready;
   assign mb_end    = (cnt == 6'(BEATS_PER_MB - 1));
   assign row_end   = mb_end && (mb_x == MBX_W'(MB_COLS - 1));
   assign frame_end = row_end && (mb_y == MBY_W'(MB_ROWS - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (fire && frame_end) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         RUN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // The final beat wraps every counter back to zero, so IDLE and DONE always present origin.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         mb_x   <= '0;
         mb_y   <= '0;
         mode_q <= MB_RASTER;
      end else if (state == IDLE && start) begin
         cnt    <= '0;
         mb_x   <= '0;
         mb_y   <= '0;
         mode_q <= scan_mode_e'(mode);
      end else if (fire) begin
         cnt <= cnt + 6'd1;
         if (mb_end) begin
            if (row_end) begin
               mb_x <= '0;
               mb_y <= frame_end ? '0 : mb_y + MBY_W'(1);
            end else begin
               mb_x <= mb_x + MBX_W'(1);
            end
         end
      end
   end

   mb_beat_decode u_decode (
      .mode    (mode_q),
      .cnt     (cnt),
      .x_off   (x_off),
      .y_off   (y_off),
      .blk_idx (blk_idx)
   );

   assign x    = {mb_x, x_off};
   assign y    = {mb_y, y_off};
   assign addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

   assign first_in_mb   = out_valid && (cnt == 6'd0);
   assign last_in_mb    = out_valid && mb_end;
   assign last_in_mbrow = out_valid && row_end;
   assign last_in_frame = out_valid && frame_end;

endmodule

// File: doc/mb_scan_addr_gen.md
# mb_scan_addr_gen

Parametrised macroblock scan address generator for the H.264 encoder data-handling path. It walks a WIDTH×HEIGHT luma frame macroblock by macroblock (raster order of 16×16 MBs). Within each MB it emits one 4-pixel row segment per beat, either in MB-raster order or in H.264 4×4 double-Z block order. Downstream fetch logic consumes each beat through a valid/ready handshake, and the block reports position flags and frame completion.

## Interface
- WIDTH, 352, frame width in pixels; multiple of 16 (elaboration-time check)
- HEIGHT, 288, frame height in pixels; multiple of 16 (elaboration-time check)
- X_W, $clog2(WIDTH), x coordinate width (derived)
- Y_W, $clog2(HEIGHT), y coordinate width (derived)
- ADDR_W, $clog2(WIDTH*HEIGHT), linear address width (derived)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame scan; honoured only in IDLE
- mode  in  1  scan_mode_e; 0 = MB_RASTER, 1 = BLK4_ZZ; sampled on accepted start
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- x  out  X_W  pixel x of first pixel in the segment
- y  out  Y_W  pixel y of the segment
- addr  out  ADDR_W  y*WIDTH + x
- mb_x / mb_y  out  X_W-4 / Y_W-4  current MB column / row
- blk_idx  out  4  4×4 block index within the MB (H.264 numbering in both modes)
- first_in_mb, last_in_mb, last_in_mbrow, last_in_frame  out  1 each  position flags, valid with out_valid
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE → RUN on start; RUN → DONE when the handshake completes on the beat with last_in_frame; DONE → IDLE unconditionally.
- Counters: beat counter cnt[5:0] (64 beats per MB), mb_x, mb_y. All advance only on out_valid && out_ready.
- MB_RASTER: row = cnt[5:2], x_off = 4*cnt[1:0], y_off = row.
- BLK4_ZZ: b = cnt[5:2], r = cnt[1:0], x_off = 4*{b[2],b[0]}, y_off = 4*{b[3],b[1]} + r.
- blk_idx = {row[3:2], x_off[3:2]} mapped to H.264 order in MB_RASTER mode; = b in BLK4_ZZ mode.
- x = 16*mb_x + x_off; y = 16*mb_y + y_off; addr is computed from the registered state. No combinational path runs from out_ready to any output.
- Wrap: cnt 63→0 increments mb_x. mb_x at WIDTH/16−1 wraps to 0 and increments mb_y.
- Flags:
  - first_in_mb: cnt==0.
  - last_in_mb: cnt==63.
  - last_in_mbrow: last_in_mb && mb_x==WIDTH/16−1.
  - last_in_frame: last_in_mbrow && mb_y==HEIGHT/16−1.
- start in RUN or DONE is ignored. mode changes after start are ignored.
- out_valid is held until accepted. Outputs are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: out_valid=0, busy=0, done=0, all counters and outputs 0, all flags 0.
- First beat: out_valid rises the cycle after start is accepted (1-cycle latency), with x=y=addr=0 and first_in_mb=1.
- Throughput: one beat per cycle while out_ready=1; 64·(WIDTH/16)·(HEIGHT/16) beats per frame.
- done: asserts the cycle after the final handshake. out_valid=0 in that cycle. busy drops together with the done assertion.
- Reset during RUN returns to IDLE next edge; no done pulse is emitted.

## Structure
- Shared package h264_pkg:
  - scan_mode_e enum.
  - Constants MB_SIZE=16, BLK_SIZE=4, BEATS_PER_MB=64.
  - Function mapping raster 4×4 position to H.264 block index.
- Sub-module mb_beat_decode: combinational map from (mode, cnt) to x_off, y_off, blk_idx. It is reusable by the chroma scan.

## Test plan
- WIDTH=HEIGHT=32, MB_RASTER, out_ready=1, start:
  - 256 beats.
  - Beat 1 is (x=4, y=0, addr=4).
  - Beat 64 is (x=16, y=0, first_in_mb=1, mb_x=1).
  - done arrives 1 cycle after beat 255, which has (x=28, y=31, addr=1020, last_in_frame=1).
- BLK4_ZZ, same frame:
  - Beats 0–3: x=0, y=0..3, blk_idx 0.
  - Beat 4: x=4, y=0, blk_idx 1.
  - Beat 8: x=0, y=4, blk_idx 2.
  - Beat 63: x=12, y=15, last_in_mb=1.
- Random out_ready backpressure (30% low): the beat sequence is identical to the no-stall run, and outputs are stable during stalls.
- start pulsed mid-RUN and mode toggled: no restart, the order is unchanged, and a single done is produced.
- reset asserted at beat 100: next cycle out_valid=0, busy=0, no done. A new start resumes from x=y=0.
- Default 352×288: 25344 beats; the final beat has addr=101372, last_in_frame=1.
